// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory handshake FSM with MEM/WB register and stall counter.
module mem_stage_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] MEM_alu_out,
    input  logic [XLEN-1:0] MEM_b2,
    input  logic [4:0]      MEM_rd,
    input  logic            MEM_we,
    input  logic            MEM_ld,
    input  logic            MEM_str,
    input  logic            MEM_byt,
    output logic            MEM_stall,
    output logic            dmem_req,
    output logic            dmem_wr,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] WB_data,
    output logic [4:0]      WB_rd,
    output logic            WB_we,
    output logic [31:0]     stall_cnt
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;
    logic mem_op, is_st;
    logic [1:0] k;
    logic [7:0] lane;
    logic [XLEN-1:0] ld_data;
    // Request fields come straight from the frozen EX/MEM register, so they stay stable through WAIT.
    always_comb begin
        mem_op     = MEM_ld | MEM_str;
        is_st      = MEM_str & ~MEM_ld;
        k          = MEM_alu_out[1:0];
        lane       = dmem_rdata[8*k +: 8];
        ld_data    = MEM_byt ? XLEN'(lane) : dmem_rdata;
        MEM_stall  = (state == IDLE) ? mem_op : ~dmem_ready;
        dmem_req   = state == WAIT;
        dmem_wr    = is_st;
        dmem_addr  = {MEM_alu_out[XLEN-1:2], 2'b00};
        dmem_be    = MEM_byt ? 4'b0001 << k : 4'hF;
        dmem_wdata = MEM_byt ? {(XLEN/8){MEM_b2[7:0]}} : MEM_b2;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            WB_data   <= '0;
            WB_rd     <= '0;
            WB_we     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= (state == IDLE) ? (mem_op ? WAIT : IDLE) : (dmem_ready ? IDLE : WAIT);
            WB_we     <= ~MEM_stall & ~is_st & MEM_we;
            WB_rd     <= MEM_stall ? '0 : MEM_rd;
            WB_data   <= MEM_stall ? '0 : MEM_ld ? ld_data : MEM_alu_out;
            stall_cnt <= stall_cnt + 32'(MEM_stall && stall_cnt != '1);
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed plus randomized checks of mem_stage_ctrl against a transaction-level model.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] MEM_alu_out = '0, MEM_b2 = '0;
    logic [4:0]  MEM_rd = '0;
    logic        MEM_we = 1'b0, MEM_ld = 1'b0, MEM_str = 1'b0, MEM_byt = 1'b0;
    logic        MEM_stall, dmem_req, dmem_wr;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] WB_data;
    logic [4:0]  WB_rd;
    logic        WB_we;
    logic [31:0] stall_cnt;

    mem_stage_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .MEM_alu_out(MEM_alu_out), .MEM_b2(MEM_b2), .MEM_rd(MEM_rd),
        .MEM_we(MEM_we), .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_byt(MEM_byt),
        .MEM_stall(MEM_stall),
        .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .WB_data(WB_data), .WB_rd(WB_rd), .WB_we(WB_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    // Model: cycles the current instruction has been held, plus expected MEM/WB contents.
    int m_age = 0;
    logic [31:0] m_wb_data = '0, m_cnt = '0;
    logic [4:0]  m_wb_rd = '0;
    logic        m_wb_we = 1'b0;
    logic        known = 1'b0;
    logic        held = 1'b0;
    int req_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_instr(input logic ld, input logic st, input logic byt, input logic we,
                             input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] b2);
        MEM_ld = ld; MEM_str = st; MEM_byt = byt; MEM_we = we;
        MEM_rd = rd; MEM_alu_out = alu; MEM_b2 = b2;
    endtask

    task automatic step(input logic r, input logic rdy, input logic [31:0] rdata);
        logic mem_op, st, exp_stall, exp_req;
        int k;
        logic [31:0] ld_res;
        rst = r; dmem_ready = rdy; dmem_rdata = rdata;
        #3;
        mem_op = MEM_ld || MEM_str;
        st = MEM_str && !MEM_ld;
        exp_stall = mem_op && (m_age == 0 || !rdy);
        exp_req = mem_op && m_age > 0;
        k = int'(MEM_alu_out % 4);
        if (known) begin
            check("stall", 32'(MEM_stall), 32'(exp_stall));
            check("req", 32'(dmem_req), 32'(exp_req));
            if (exp_req) begin
                req_seen++;
                check("addr", dmem_addr, MEM_alu_out & ~32'd3);
                check("wr", 32'(dmem_wr), 32'(st));
                check("be", 32'(dmem_be), MEM_byt ? (32'd1 << k) : 32'hF);
                check("wdata", dmem_wdata, MEM_byt ? 32'(MEM_b2[7:0]) * 32'h01010101 : MEM_b2);
            end
        end
        ld_res = MEM_byt ? (rdata >> (8 * k)) & 32'hFF : rdata;
        if (r) begin
            m_wb_data = '0; m_wb_rd = '0; m_wb_we = 1'b0; m_cnt = '0; m_age = 0;
        end else if (exp_stall) begin
            m_wb_data = '0; m_wb_rd = '0; m_wb_we = 1'b0; m_age++;
            if (m_cnt != 32'hFFFFFFFF) m_cnt++;
        end else begin
            m_wb_rd = MEM_rd; m_age = 0;
            m_wb_data = MEM_ld ? ld_res : MEM_alu_out;
            m_wb_we = MEM_str && !MEM_ld ? 1'b0 : MEM_we;
        end
        held = exp_stall && !r;
        if (r) known = 1'b1;
        @(posedge clk);
        #1;
        check("wb_data", WB_data, m_wb_data);
        check("wb_rd", 32'(WB_rd), 32'(m_wb_rd));
        check("wb_we", 32'(WB_we), 32'(m_wb_we));
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    initial begin
        step(1'b1, 1'b0, '0);
        // ALU op writes back next cycle without stalling
        set_instr(0, 0, 0, 1, 5'd5, 32'h1234, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        check("alu_wb", WB_data, 32'h1234);
        // word load with three WAIT cycles before ready
        set_instr(1, 0, 0, 1, 5'd7, 32'h100, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hDEADBEEF);
        check("ld_word", WB_data, 32'hDEADBEEF);
        check("ld_cnt", stall_cnt, 32'd4);
        // byte store to lane 3
        set_instr(0, 1, 1, 1, 5'd3, 32'h103, 32'h000000AB);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        check("st_wb_we", 32'(WB_we), 32'd0);
        // byte load from lane 2
        set_instr(1, 0, 1, 1, 5'd9, 32'h102, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h11223344);
        check("ld_byte", WB_data, 32'h00000022);
        // reset while in WAIT abandons the access
        set_instr(1, 0, 0, 1, 5'd4, 32'h200, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("rst_cnt", stall_cnt, 32'd0);
        set_instr(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        // back-to-back load then store with immediate ready
        set_instr(1, 0, 0, 1, 5'd1, 32'h300, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'hCAFEF00D);
        set_instr(0, 1, 0, 0, 5'd2, 32'h304, 32'h55AA55AA);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        check("b2b_cnt", stall_cnt, 32'd2);
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (!held) begin
                int t;
                t = int'($urandom_range(0, 3));
                set_instr(t == 1 || t == 3, t == 2 || t == 3, 1'($urandom), 1'($urandom),
                          5'($urandom), $urandom, $urandom);
            end
            step($urandom_range(0, 49) == 0, 1'($urandom), $urandom);
        end
        check("req_coverage", 32'(req_seen > 50), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/address width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have inputs MEM_alu_out [XLEN], MEM_b2 [XLEN], MEM_rd [5], MEM_we, MEM_ld, MEM_str, MEM_byt [1 each]: MEM-stage instruction fields from the EX/MEM register.
REQ-005 SHALL have output MEM_stall, 1, freezing the EX/MEM register and all upstream stages while high.
REQ-006 SHALL have outputs dmem_req, dmem_wr [1], dmem_addr [XLEN], dmem_wdata [XLEN], dmem_be [4]: data-memory request port.
REQ-007 SHALL have inputs dmem_ready [1] and dmem_rdata [XLEN]: data-memory completion and load data.
REQ-008 SHALL have outputs WB_data [XLEN], WB_rd [5], WB_we [1]: registered MEM/WB fields.
REQ-009 SHALL have output stall_cnt [32]: saturating count of MEM_stall-high cycles.

Function
REQ-010 SHALL implement FSM states IDLE and WAIT.
REQ-011 A memory op SHALL be MEM_ld or MEM_str; when both are high, the op SHALL be treated as a load.
REQ-012 IDLE: if a memory op is present, the FSM SHALL go to WAIT on the next edge and MEM_stall SHALL be 1 in that cycle; otherwise the FSM SHALL stay in IDLE.
REQ-013 WAIT: dmem_req SHALL be 1, and addr/wdata/be/wr SHALL be held stable until the cycle dmem_ready=1.
REQ-014 WAIT with dmem_ready=0: MEM_stall SHALL be 1 and the FSM SHALL stay in WAIT.
REQ-015 WAIT with dmem_ready=1: MEM_stall SHALL be 0 and the FSM SHALL return to IDLE on the next edge.
REQ-016 dmem_req SHALL be 0 in IDLE, so every access is a minimum of 2 cycles.
REQ-017 dmem_addr SHALL be {MEM_alu_out[XLEN-1:2], 2'b00}, and dmem_wr SHALL be 1 only for a store.
REQ-018 Word access (MEM_byt=0) SHALL use dmem_be=4'hF, dmem_wdata=MEM_b2, and load result dmem_rdata.
REQ-019 Byte access SHALL use lane k=MEM_alu_out[1:0] and dmem_be=1<<k.
REQ-020 A byte store SHALL drive dmem_wdata = MEM_b2[7:0] replicated in all four lanes.
REQ-021 A byte load SHALL return dmem_rdata[8k+7:8k], zero-extended to XLEN.
REQ-022 The MEM/WB register SHALL update on every edge.
REQ-023 When MEM_stall=1, the MEM/WB register SHALL load a bubble: WB_we=0, WB_rd=0, WB_data=0.
REQ-024 When MEM_stall=0 on a load completion, the MEM/WB register SHALL load WB_data=load result, WB_rd=MEM_rd, WB_we=MEM_we.
REQ-025 When MEM_stall=0 on a store completion, the MEM/WB register SHALL load WB_we=0, WB_rd=MEM_rd, WB_data=MEM_alu_out.
REQ-026 When MEM_stall=0 with no memory op, the MEM/WB register SHALL load WB_data=MEM_alu_out, WB_rd=MEM_rd, WB_we=MEM_we.
REQ-027 Because the EX/MEM register advances on the completion edge, the next memory op SHALL re-enter at IDLE, and back-to-back ops SHALL each take at least 2 cycles.
REQ-028 A dmem_ready pulse while in IDLE SHALL be ignored.
REQ-029 stall_cnt SHALL increment by 1 on each edge where MEM_stall=1 and SHALL saturate at 32'hFFFFFFFF.
REQ-030 MEM_stall, dmem_* outputs and the byte-lane logic SHALL be combinational from state and inputs; WB_* outputs and stall_cnt SHALL be registered.

Reset
REQ-031 On rst=1 at an edge: state SHALL go to IDLE, WB_data=0, WB_rd=0, WB_we=0, stall_cnt=0.
REQ-032 A reset during WAIT SHALL abandon the access: dmem_req=0 from the next cycle and no writeback shall occur.
REQ-033 In the rst cycle, combinational outputs SHALL follow the pre-reset state; from the first post-reset cycle they SHALL reflect IDLE.

Verification
REQ-034 ALU op (ld=str=0, we=1, rd=5, alu_out=0x1234) -> next cycle WB_data=0x1234, WB_rd=5, WB_we=1, MEM_stall never 1.
REQ-035 Word load at addr 0x100, dmem_ready after 3 WAIT cycles with rdata=0xDEADBEEF -> stall high 4 cycles, one WB_we=1 with WB_data=0xDEADBEEF, bubbles before it, stall_cnt=4.
REQ-036 Byte store of b2=0x000000AB to addr 0x103 -> dmem_addr=0x100, be=4'b1000, wdata=0xABABABAB, wr=1, WB_we=0.
REQ-037 Byte load from addr 0x102 with rdata=0x11223344 -> WB_data=0x00000022.
REQ-038 rst asserted during WAIT -> next cycle dmem_req=0, MEM_stall reflects IDLE, WB_we=0, stall_cnt=0.
REQ-039 Back-to-back load then store, each with immediate dmem_ready -> each takes 2 cycles, dmem_req low for the IDLE cycle between them.
